// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Counter widths come from width_of() so that single-value ranges still get one bit.
package seg_scan_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_ON    = 1'b1
  } phase_e;

  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero suppression mask: walks from the most significant digit down and
// blanks zero digits until an enabled digit that is non-zero or carries a dp.
module seg_lz_mask #(
  parameter int NDIG = 4
) (
  input  logic [4*NDIG-1:0] data_i,
  input  logic [NDIG-1:0]   en_i,
  input  logic [NDIG-1:0]   dp_i,
  input  logic              lz_en_i,
  output logic [NDIG-1:0]   suppress_o
);

  always_comb begin
    logic run;
    suppress_o = '0;
    run        = lz_en_i;
    // Digit 0 is excluded so a value of zero still shows a single "0".
    // Disabled digits neither suppress nor stop the run.
    for (int i = NDIG - 1; i >= 1; i--) begin
      if (en_i[i]) begin
        if ((data_i[4*i +: 4] == 4'h0) && !dp_i[i]) begin
          suppress_o[i] = run;
        end else begin
          run = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: slot/digit counters, blanking, double-
// buffered host writes committed on the frame boundary, registered outputs.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NDIG         = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [4*NDIG-1:0] data_in,
  input  logic [NDIG-1:0]   dp_in,
  input  logic [NDIG-1:0]   en_in,
  input  logic              lz_en,
  output logic [3:0]        bcd,
  output logic [NDIG-1:0]   an,
  output logic              dp,
  output logic              frame_tick
);

  localparam int CNT_W = width_of(SLOT_CYCLES);
  localparam int IDX_W = width_of(NDIG);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIG - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [4*NDIG-1:0] shadow_data_q, shadow_data_d;
  logic [NDIG-1:0]   shadow_dp_q, shadow_dp_d;
  logic [NDIG-1:0]   shadow_en_q, shadow_en_d;
  logic [4*NDIG-1:0] active_data_q, active_data_d;
  logic [NDIG-1:0]   active_dp_q, active_dp_d;
  logic [NDIG-1:0]   active_en_q, active_en_d;
  logic              pending_q, pending_d;
  logic [3:0]        bcd_q, bcd_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic              dp_q, dp_d;
  logic              tick_q, tick_d;

  logic              slot_end, frame_end, show_d;
  phase_e            phase_d;
  logic [NDIG-1:0]   suppress;

  seg_lz_mask #(.NDIG(NDIG)) u_lz_mask (
    .data_i     (active_data_d),
    .en_i       (active_en_d),
    .dp_i       (active_dp_d),
    .lz_en_i    (lz_en),
    .suppress_o (suppress)
  );

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);

    cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    shadow_en_d   = shadow_en_q;
    active_data_d = active_data_q;
    active_dp_d   = active_dp_q;
    active_en_d   = active_en_q;
    pending_d     = pending_q;

    // Commit uses the pre-edge shadow; a coincident load lands in shadow and re-arms pending.
    if (frame_end && pending_q) begin
      active_data_d = shadow_data_q;
      active_dp_d   = shadow_dp_q;
      active_en_d   = shadow_en_q;
      pending_d     = 1'b0;
    end
    if (load) begin
      shadow_data_d = data_in;
      shadow_dp_d   = dp_in;
      shadow_en_d   = en_in;
      pending_d     = 1'b1;
    end

    // Outputs are registered from next-state values so they line up with cnt_q/idx_q.
    phase_d = (cnt_d < BLANK_END) ? PH_BLANK : PH_ON;
    show_d  = (phase_d == PH_ON) && active_en_d[idx_d] && !suppress[idx_d];
    an_d    = show_d ? ~(NDIG'(1) << idx_d) : '1;
    bcd_d   = show_d ? active_data_d[4*int'(idx_d) +: 4] : BLANK_CODE;
    dp_d    = show_d ? ~active_dp_d[idx_d] : 1'b1;
    tick_d  = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      shadow_en_q   <= '0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      active_en_q   <= '0;
      pending_q     <= 1'b0;
      bcd_q         <= BLANK_CODE;
      an_q          <= '1;
      dp_q          <= 1'b1;
      tick_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      shadow_en_q   <= shadow_en_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      active_en_q   <= active_en_d;
      pending_q     <= pending_d;
      bcd_q         <= bcd_d;
      an_q          <= an_d;
      dp_q          <= dp_d;
      tick_q        <= tick_d;
    end
  end

  assign bcd        = bcd_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic, checked
// cycle by cycle against a frame-position reference model through a queue.
module tb_seg_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = NDIG * SLOT;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  en_in = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        dp;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NDIG(NDIG), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk), .clr(clr), .load(load), .data_in(data_in), .dp_in(dp_in),
    .en_in(en_in), .lz_en(lz_en), .bcd(bcd), .an(an), .dp(dp),
    .frame_tick(frame_tick)
  );

  // Expected {an, bcd, dp, frame_tick}
  logic [9:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: position within the frame plus shadow/active copies.
  int          m_pos = 0;
  logic [15:0] m_sh_data, m_act_data;
  logic [3:0]  m_sh_dp, m_sh_en, m_act_dp, m_act_en;
  bit          m_pending;

  function automatic bit suppressed(int d, bit lz);
    logic [15:0] dat;
    if (!lz || d == 0) return 1'b0;
    dat = m_act_data;
    for (int j = d; j < NDIG; j++) begin
      if (m_act_en[j] && ((dat[4*j +: 4] != 4'h0) || m_act_dp[j])) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [9:0] expected_out(bit lz);
    int d, c;
    bit vis;
    logic [15:0] dat;
    logic [3:0] a;
    d = m_pos / SLOT;
    c = m_pos % SLOT;
    dat = m_act_data;
    vis = (c >= BLANK) && m_act_en[d] && !suppressed(d, lz);
    a = 4'b0001 << d;
    if (vis) return {~a, dat[4*d +: 4], ~m_act_dp[d], m_pos == FRAME - 1};
    return {4'hF, 4'hF, 1'b1, m_pos == FRAME - 1};
  endfunction

  task automatic model_step();
    if (clr) begin
      m_pos = 0;
      m_sh_data = '0; m_sh_dp = '0; m_sh_en = '0;
      m_act_data = '0; m_act_dp = '0; m_act_en = '0;
      m_pending = 1'b0;
      exp_q.push_back({4'hF, 4'hF, 1'b1, 1'b0});
    end else begin
      if (m_pos == FRAME - 1 && m_pending) begin
        m_act_data = m_sh_data; m_act_dp = m_sh_dp; m_act_en = m_sh_en;
        m_pending = 1'b0;
      end
      if (load) begin
        m_sh_data = data_in; m_sh_dp = dp_in; m_sh_en = en_in;
        m_pending = 1'b1;
      end
      m_pos = (m_pos + 1) % FRAME;
      exp_q.push_back(expected_out(lz_en));
    end
  endtask

  // ---- clock/driver tasks ----
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to(int p);
    for (int i = 0; i < FRAME && m_pos != p; i++) cycle();
  endtask

  task automatic do_load(logic [15:0] d, logic [3:0] p, logic [3:0] e);
    data_in = d; dp_in = p; en_in = e; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  // ---- monitor ----
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      vectors++;
      if ({an, bcd, dp, frame_tick} !== e) begin
        miscompares++;
        $display("FAIL out @%0t: got an=%b bcd=%h dp=%b tick=%b, want an=%b bcd=%h dp=%b tick=%b",
                 $time, an, bcd, dp, frame_tick, e[9:6], e[5:2], e[1], e[0]);
      end
    end
  end

  // ---- stimulus ----
  initial begin
    #1;
    run(3);
    clr = 1'b0;
    run(70);

    run_to(12);
    do_load(16'h1234, 4'h0, 4'hF);
    run(2 * FRAME);

    lz_en = 1'b1;
    do_load(16'h0050, 4'h0, 4'hF);
    run(2 * FRAME);
    do_load(16'h0050, 4'b0100, 4'hF);
    run(2 * FRAME);

    run_to(5);
    do_load(16'hAAAA, 4'h0, 4'hF);
    run_to(20);
    do_load(16'hBBBB, 4'h0, 4'hF);
    run(FRAME + 4);
    run_to(10);
    do_load(16'hCCCC, 4'h1, 4'hF);
    run_to(FRAME - 1);
    do_load(16'hDDDD, 4'h0, 4'hF);
    run(2 * FRAME + 4);

    do_load(16'h8888, 4'h0, 4'b0101);
    run(2 * FRAME);

    run_to(2 * SLOT + 4);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    run(2 * FRAME);
    do_load(16'h0007, 4'h0, 4'hF);
    run(2 * FRAME);

    for (int k = 0; k < 800; k++) begin
      logic [15:0] d;
      for (int n = 0; n < NDIG; n++)
        d[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      data_in = d;
      dp_in   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      en_in   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      load    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 29) == 0) lz_en = ~lz_en;
      clr     = ($urandom_range(0, 299) == 0);
      cycle();
    end
    load = 1'b0;
    clr  = 1'b0;
    run(4);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
